// File: rtl/hazard_fwd_if.sv
// Hazard unit bus: ID/EX/MEM/WB pipeline fields in, forwarding selects,
// stall controls and MULT/DIV status out.
interface hazard_fwd_if #(
    parameter int AW  = 5,
    parameter int SCW = 16
);
    logic [AW-1:0]  D_Rs, D_Rt;
    logic           D_UseRs, D_UseRt, D_UseHiLo, D_MCOp;
    logic [AW-1:0]  E_Rs, E_Rt, E_Rw;
    logic           E_ALUSrc, E_MemRd, E_MCStart;
    logic [AW-1:0]  M_Rw, W_Rw;
    logic           M_RegWr, W_RegWr;
    logic           Cnt_Clr;
    logic [1:0]     ALUSrcA, ALUSrcB;
    logic           F_Stall, D_Stall, E_Flush;
    logic           MC_Busy, MC_Done;
    logic [SCW-1:0] StallCnt;

    modport master (
        output D_Rs, D_Rt, D_UseRs, D_UseRt, D_UseHiLo, D_MCOp,
        output E_Rs, E_Rt, E_Rw, E_ALUSrc, E_MemRd, E_MCStart,
        output M_Rw, W_Rw, M_RegWr, W_RegWr, Cnt_Clr,
        input  ALUSrcA, ALUSrcB, F_Stall, D_Stall, E_Flush,
        input  MC_Busy, MC_Done, StallCnt
    );

    modport slave (
        input  D_Rs, D_Rt, D_UseRs, D_UseRt, D_UseHiLo, D_MCOp,
        input  E_Rs, E_Rt, E_Rw, E_ALUSrc, E_MemRd, E_MCStart,
        input  M_Rw, W_Rw, M_RegWr, W_RegWr, Cnt_Clr,
        output ALUSrcA, ALUSrcB, F_Stall, D_Stall, E_Flush,
        output MC_Busy, MC_Done, StallCnt
    );
endinterface

// File: rtl/hazard_fwd_unit.sv
// EX operand forwarding, load-use / MULT-DIV stalls and MULT-DIV occupancy countdown.
// Optional stall-cycle counter enabled by defining HAZARD_STALL_CNT_EN.
//
// state  | meaning
// S_IDLE | MULT/DIV unit free, cnt == 0
// S_BUSY | MULT/DIV occupied, cnt counts down to 0
module hazard_fwd_unit #(
    parameter int AW     = 5,
    parameter int MC_LAT = 4,
    parameter int CW     = 3,
    parameter int SCW    = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    hazard_fwd_if.slave  hz
);
    typedef enum logic {S_IDLE = 1'b0, S_BUSY = 1'b1} state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic          mc_done, done_nxt;

    logic c1a, c2a, c1b, c2b;
    logic load_use, mc_hazard, stall;

    assign c1a = hz.M_RegWr && (hz.M_Rw != '0) && (hz.E_Rs != '0) && (hz.M_Rw == hz.E_Rs);
    assign c2a = hz.W_RegWr && (hz.W_Rw != '0) && (hz.E_Rs != '0) && (hz.W_Rw == hz.E_Rs);
    assign c1b = hz.M_RegWr && (hz.M_Rw != '0) && (hz.E_Rt != '0) && (hz.M_Rw == hz.E_Rt);
    assign c2b = hz.W_RegWr && (hz.W_Rw != '0) && (hz.E_Rt != '0) && (hz.W_Rw == hz.E_Rt);

    // MEM holds the younger result, so it wins over WB
    assign hz.ALUSrcA = c1a ? 2'b01 : c2a ? 2'b10 : 2'b00;
    assign hz.ALUSrcB = hz.E_ALUSrc ? 2'b11 : c1b ? 2'b01 : c2b ? 2'b10 : 2'b00;

    assign load_use  = hz.E_MemRd && (hz.E_Rw != '0) &&
                       ((hz.D_UseRs && (hz.D_Rs == hz.E_Rw)) ||
                        (hz.D_UseRt && (hz.D_Rt == hz.E_Rw)));
    assign mc_hazard = (hz.D_UseHiLo || hz.D_MCOp) && (hz.MC_Busy || hz.E_MCStart);
    assign stall     = load_use || mc_hazard;

    assign hz.F_Stall = stall;
    assign hz.D_Stall = stall;
    assign hz.E_Flush = stall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            cnt     <= '0;
            mc_done <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            mc_done <= done_nxt;
        end
    end

    // A new start while busy is dropped; the ID stage is already stalled behind it
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        done_nxt  = 1'b0;
        case (state)
            S_IDLE: begin
                if (hz.E_MCStart) begin
                    cnt_nxt   = CW'(MC_LAT);
                    state_nxt = S_BUSY;
                end
            end
            S_BUSY: begin
                cnt_nxt = cnt - CW'(1);
                if (cnt == CW'(1)) begin
                    state_nxt = S_IDLE;
                    done_nxt  = 1'b1;
                end
            end
            default: begin
                state_nxt = S_IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    assign hz.MC_Busy = (cnt != '0);
    assign hz.MC_Done = mc_done;

`ifdef HAZARD_STALL_CNT_EN
    logic [SCW-1:0] stall_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            stall_cnt <= '0;
        else if (hz.Cnt_Clr)
            stall_cnt <= '0;
        else if (stall && (stall_cnt != '1))
            stall_cnt <= stall_cnt + SCW'(1);
    end

    assign hz.StallCnt = stall_cnt;
`else
    logic unused_cnt_clr;

    assign unused_cnt_clr = hz.Cnt_Clr;
    assign hz.StallCnt    = '0;
`endif
endmodule

// File: tb/tb_hazard_fwd_unit.sv
// Directed bench for hazard_fwd_unit with a per-cycle expected-output scoreboard.
module tb_hazard_fwd_unit;
    localparam int AW     = 5;
    localparam int MC_LAT = 4;
    localparam int CW     = 3;
    localparam int SCW    = 2;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    hazard_fwd_if #(.AW(AW), .SCW(SCW)) bus ();

    hazard_fwd_unit #(.AW(AW), .MC_LAT(MC_LAT), .CW(CW), .SCW(SCW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .hz    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string          tag;
        logic [1:0]     a;
        logic [1:0]     b;
        logic           st;
        logic           bs;
        logic           dn;
        logic [SCW-1:0] cnt;
    } exp_t;

    exp_t           sbq[$];
    logic [SCW-1:0] exp_cnt;

    task automatic clear_inputs();
        bus.D_Rs = '0; bus.D_Rt = '0; bus.D_UseRs = 0; bus.D_UseRt = 0;
        bus.D_UseHiLo = 0; bus.D_MCOp = 0;
        bus.E_Rs = '0; bus.E_Rt = '0; bus.E_Rw = '0;
        bus.E_ALUSrc = 0; bus.E_MemRd = 0; bus.E_MCStart = 0;
        bus.M_Rw = '0; bus.W_Rw = '0; bus.M_RegWr = 0; bus.W_RegWr = 0;
        bus.Cnt_Clr = 0;
    endtask

    task automatic expect_out(input string tag, input logic [1:0] a, input logic [1:0] b,
                              input logic st, input logic bs, input logic dn);
        exp_t e;
        e.tag = tag; e.a = a; e.b = b; e.st = st; e.bs = bs; e.dn = dn;
`ifdef HAZARD_STALL_CNT_EN
        e.cnt = exp_cnt;
`else
        e.cnt = '0;
`endif
        sbq.push_back(e);
    endtask

    task automatic chk(input string tag, input string field,
                       input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v)
        else begin
            errors++;
            $error("FAIL %s.%s observed %0h expected %0h", tag, field, obs, exp_v);
        end
    endtask

    // Sample mid-cycle, then advance the stall-count model across the coming edge
    task automatic tick();
        exp_t e;
        @(negedge clk);
        if (sbq.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL scoreboard observed empty expected entry");
        end else begin
            e = sbq.pop_front();
            chk(e.tag, "ALUSrcA",  32'(bus.ALUSrcA),  32'(e.a));
            chk(e.tag, "ALUSrcB",  32'(bus.ALUSrcB),  32'(e.b));
            chk(e.tag, "F_Stall",  32'(bus.F_Stall),  32'(e.st));
            chk(e.tag, "D_Stall",  32'(bus.D_Stall),  32'(e.st));
            chk(e.tag, "E_Flush",  32'(bus.E_Flush),  32'(e.st));
            chk(e.tag, "MC_Busy",  32'(bus.MC_Busy),  32'(e.bs));
            chk(e.tag, "MC_Done",  32'(bus.MC_Done),  32'(e.dn));
            chk(e.tag, "StallCnt", 32'(bus.StallCnt), 32'(e.cnt));
            if (!rst_n || bus.Cnt_Clr)
                exp_cnt = '0;
            else if (e.st && (exp_cnt != '1))
                exp_cnt = exp_cnt + SCW'(1);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        exp_cnt = '0;
        rst_n   = 1'b0;
        clear_inputs();

        // reset state
        expect_out("reset", 2'b00, 2'b00, 0, 0, 0); tick();
        rst_n = 1'b1;
        expect_out("post_reset", 2'b00, 2'b00, 0, 0, 0); tick();

        // forwarding priority and $0
        bus.M_Rw = 8; bus.W_Rw = 8; bus.E_Rs = 8; bus.M_RegWr = 1; bus.W_RegWr = 1;
        expect_out("fwd_mem_prio", 2'b01, 2'b00, 0, 0, 0); tick();
        bus.M_RegWr = 0;
        expect_out("fwd_wb", 2'b10, 2'b00, 0, 0, 0); tick();
        bus.E_Rs = 0;
        expect_out("fwd_rs_zero", 2'b00, 2'b00, 0, 0, 0); tick();
        clear_inputs();
        bus.E_ALUSrc = 1; bus.E_Rt = 5; bus.M_Rw = 5; bus.M_RegWr = 1;
        expect_out("imm_over_mem", 2'b00, 2'b11, 0, 0, 0); tick();
        bus.E_ALUSrc = 0; bus.W_Rw = 5; bus.W_RegWr = 1;
        expect_out("fwd_b_mem", 2'b00, 2'b01, 0, 0, 0); tick();
        bus.M_Rw = 0; bus.E_Rt = 0; bus.W_Rw = 0;
        expect_out("fwd_b_r0", 2'b00, 2'b00, 0, 0, 0); tick();
        bus.E_Rt = 7; bus.W_Rw = 7; bus.M_Rw = 3;
        expect_out("fwd_b_wb", 2'b00, 2'b10, 0, 0, 0); tick();

        // load-use
        clear_inputs();
        bus.E_MemRd = 1; bus.E_Rw = 9; bus.D_Rt = 9; bus.D_UseRt = 1;
        expect_out("lu_rt", 2'b00, 2'b00, 1, 0, 0); tick();
        bus.E_MemRd = 0;
        expect_out("lu_bubble", 2'b00, 2'b00, 0, 0, 0); tick();
        bus.E_MemRd = 1; bus.D_UseRt = 0;
        expect_out("lu_rt_unused", 2'b00, 2'b00, 0, 0, 0); tick();
        bus.D_Rs = 9; bus.D_UseRs = 1;
        expect_out("lu_rs", 2'b00, 2'b00, 1, 0, 0); tick();
        bus.E_Rw = 0; bus.D_Rs = 0;
        expect_out("lu_r0", 2'b00, 2'b00, 0, 0, 0); tick();

        // MULT/DIV occupancy with mfhi held in ID; restart in cycle 2 ignored
        clear_inputs();
        bus.D_UseHiLo = 1; bus.E_MCStart = 1;
        expect_out("mc_c0", 2'b00, 2'b00, 1, 0, 0); tick();
        bus.E_MCStart = 0;
        expect_out("mc_c1", 2'b00, 2'b00, 1, 1, 0); tick();
        bus.E_MCStart = 1;
        expect_out("mc_c2", 2'b00, 2'b00, 1, 1, 0); tick();
        bus.E_MCStart = 0;
        expect_out("mc_c3", 2'b00, 2'b00, 1, 1, 0); tick();
        expect_out("mc_c4", 2'b00, 2'b00, 1, 1, 0); tick();
        expect_out("mc_c5", 2'b00, 2'b00, 0, 0, 1); tick();
        bus.D_UseHiLo = 0; bus.D_MCOp = 1;
        expect_out("mc_c6", 2'b00, 2'b00, 0, 0, 0); tick();

        // stall counter: clear, saturate, clear with stall, resume
        clear_inputs();
        bus.Cnt_Clr = 1;
        expect_out("cnt_clr_idle", 2'b00, 2'b00, 0, 0, 0); tick();
        bus.Cnt_Clr = 0;
        bus.E_MemRd = 1; bus.E_Rw = 4; bus.D_Rs = 4; bus.D_UseRs = 1;
        for (int i = 0; i < 5; i++) begin
            expect_out($sformatf("cnt_stall%0d", i), 2'b00, 2'b00, 1, 0, 0); tick();
        end
        bus.Cnt_Clr = 1;
        expect_out("cnt_clr_stall", 2'b00, 2'b00, 1, 0, 0); tick();
        bus.Cnt_Clr = 0; bus.D_MCOp = 1; bus.E_MCStart = 1;
        expect_out("cnt_lu_mh", 2'b00, 2'b00, 1, 0, 0); tick();
        clear_inputs();
        expect_out("cnt_after", 2'b00, 2'b00, 0, 1, 0); tick();

        // async reset inside a busy period
        expect_out("rst_busy_c1", 2'b00, 2'b00, 0, 1, 0); tick();
        rst_n = 1'b0;
        exp_cnt = '0;
        bus.E_Rs = 8; bus.M_Rw = 8; bus.M_RegWr = 1;
        expect_out("rst_busy_c2", 2'b01, 2'b00, 0, 0, 0); tick();
        rst_n = 1'b1;
        clear_inputs();
        for (int i = 3; i < 8; i++) begin
            expect_out($sformatf("rst_busy_c%0d", i), 2'b00, 2'b00, 0, 0, 0); tick();
        end

        if (sbq.size() != 0) begin
            checks++;
            errors++;
            $error("FAIL scoreboard_leftover observed %0d expected 0", sbq.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/hazard_fwd_unit.md
# hazard_fwd_unit

Parametrised pipeline hazard unit for the five-stage MIPS core: it generates the EX-stage ALU operand forwarding selects from MEM and WB, load-use stalls, and stalls behind a multi-cycle MULT/DIV unit that writes HI/LO. It tracks that unit's occupancy with an internal countdown and, optionally, counts front-end stall cycles. It sits beside the ID/EX register, driving the operand muxes, the PC and IF/ID hold enables, and the ID/EX bubble insert.

## Interface
- AW, 5: register address width.
- MC_LAT, 4: MULT/DIV occupancy in cycles, from 1 to 2^CW-1.
- CW, 3: MULT/DIV countdown width.
- SCW, 16: stall counter width.

- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- D_Rs, D_Rt  in  AW  ID-stage source registers
- D_UseRs, D_UseRt  in  1  ID instruction actually reads Rs / Rt
- D_UseHiLo  in  1  ID instruction reads HI/LO (mfhi/mflo)
- D_MCOp  in  1  ID instruction is MULT/DIV
- E_Rs, E_Rt  in  AW  EX-stage sources
- E_ALUSrc  in  1  operand B is the immediate
- E_Rw  in  AW  EX destination
- E_MemRd  in  1  EX instruction is a load
- E_MCStart  in  1  EX instruction is MULT/DIV
- M_Rw, W_Rw  in  AW  MEM / WB destinations
- M_RegWr, W_RegWr  in  1  MEM / WB register write enables
- Cnt_Clr  in  1  synchronous clear of the stall counter
- ALUSrcA  out  2  00 = regfile, 01 = MEM, 10 = WB
- ALUSrcB  out  2  00 = regfile, 01 = MEM, 10 = WB, 11 = immediate
- F_Stall, D_Stall  out  1  hold PC / hold IF/ID
- E_Flush  out  1  insert a bubble into ID/EX
- MC_Busy  out  1  MULT/DIV occupied
- MC_Done  out  1  one-cycle pulse after occupancy ends
- StallCnt  out  SCW  count of stalled cycles

## Operation

**Forwarding (combinational)**
- C1X = M_RegWr && M_Rw != 0 && src != 0 && M_Rw == src.
- C2X = W_RegWr && W_Rw != 0 && src != 0 && W_Rw == src.
- ALUSrcA = C1A ? 01 : C2A ? 10 : 00.
- ALUSrcB = E_ALUSrc ? 11 : C1B ? 01 : C2B ? 10 : 00.
- MEM takes priority over WB when both match.

**Load-use (combinational)**
- LU = E_MemRd && E_Rw != 0 && ((D_UseRs && D_Rs == E_Rw) || (D_UseRt && D_Rt == E_Rw)).

**Multi-cycle hazard**
- MH = (D_UseHiLo || D_MCOp) && (MC_Busy || E_MCStart).

**Stall outputs**
- Stall = LU || MH.
- F_Stall = D_Stall = E_Flush = Stall.

**Countdown FSM**
- States: IDLE (cnt == 0) and BUSY (cnt != 0). MC_Busy = (cnt != 0).
- IDLE with E_MCStart: cnt <= MC_LAT, go to BUSY.
- BUSY: cnt decrements by 1 per cycle. E_MCStart is ignored, including when cnt == 1.
- MC_Done is registered and high for exactly the one cycle after cnt goes 1 -> 0.

**Stall counter**
- Cnt_Clr has priority: StallCnt <= 0.
- Otherwise StallCnt increments on every cycle with Stall == 1.
- It saturates at all-ones and does not wrap.

## Timing
- Reset (asynchronous, rst_n = 0): cnt = 0, MC_Busy = 0, MC_Done = 0, StallCnt = 0.
- Outputs during and after reset:
  - Combinational outputs follow their inputs, so they also follow them during reset.
  - With all inputs at 0: ALUSrcA = ALUSrcB = 00 and all stalls are 0.
- Reset in the middle of a busy period aborts it immediately. No MC_Done is issued.
- Forwarding and stall outputs have zero latency: they are valid in the same cycle as their inputs.
- E_MCStart sampled at edge t:
  - MC_Busy is high for cycles t+1 .. t+MC_LAT.
  - MC_Done is high in cycle t+MC_LAT+1.
  - An mfhi in ID stalls from cycle t (via E_MCStart) through cycle t+MC_LAT.
- MC_LAT = 1: MC_Busy is high for a single cycle.
- Load-use stalls for exactly one cycle. The bubble it inserts clears E_MemRd on the next cycle.
- LU and MH together produce a single stall per cycle. StallCnt counts that cycle once.

## Configuration
- HAZARD_STALL_CNT_EN
  - Defined: the stall counter register and the Cnt_Clr logic are present.
  - Undefined: StallCnt is tied to 0, Cnt_Clr is ignored, and no counter flops are synthesised.
- All other behaviour is identical in both builds.

## Test plan
- **Forwarding priority.** M_Rw = W_Rw = E_Rs = 8, both RegWr = 1 -> ALUSrcA = 01. Set M_RegWr = 0 -> 10. Set E_Rs = 0 -> 00.
- **Immediate and $0.** E_ALUSrc = 1 with a MEM match on Rt -> ALUSrcB = 11. E_ALUSrc = 0, M_Rw = 0 = E_Rt, M_RegWr = 1 -> 00.
- **Load-use.** E_MemRd = 1, E_Rw = 9, D_Rt = 9, D_UseRt = 1 -> F_Stall = D_Stall = E_Flush = 1 for one cycle. With D_UseRt = 0 -> 0.
- **MULT/DIV occupancy, MC_LAT = 4.**
  - Stimulus: pulse E_MCStart at cycle 0, hold D_UseHiLo = 1.
  - Required: Stall high for cycles 0–4, MC_Busy high for cycles 1–4, MC_Done high in cycle 5.
  - A second E_MCStart in cycle 2 is ignored.
- **Async reset in busy period.** Drop rst_n in cycle 2 -> MC_Busy = 0 immediately, MC_Done never pulses, StallCnt = 0.
- **Counter (HAZARD_STALL_CNT_EN defined, SCW = 2).**
  - 5 stalled cycles -> StallCnt = 3 (saturated).
  - Cnt_Clr asserted together with Stall -> StallCnt = 0 on the next cycle.
  - With the macro undefined -> StallCnt stays 0 throughout.
